// File: rtl/alu_acumulador.sv
// Execution unit and main accumulator of the 4-bit CPU.
// Ports: C_i clock, rst_i sync reset, ACT_i/OPC_i operand and opcode,
// start_i/busy_o/done_o handshake, ACC_o accumulator, REM_o remainder,
// Z_o/C_o/E_o zero, carry-borrow-overflow and divide-by-zero flags.
module alu_acumulador #(
   parameter int W    = 4,
   parameter int N_IT = W
) (
   input  logic         C_i,
   input  logic         rst_i,
   input  logic [W-1:0] ACT_i,
   input  logic [2:0]   OPC_i,
   input  logic         start_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] ACC_o,
   output logic [W-1:0] REM_o,
   output logic         Z_o,
   output logic         C_o,
   output logic         E_o
);

   localparam int CW = (N_IT > 1) ? $clog2(N_IT) : 1;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_MUL  = 3'b110;
   localparam logic [2:0] OP_DIV  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE, S_EXEC, S_MUL, S_DIV
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0]   acc_q, rem_q, opd_q, quo_q;
   logic [2:0]     opc_q;
   logic [CW-1:0]  cnt_q;
   logic [2*W-1:0] prod_q;
   logic [W:0]     r_q;
   logic           z_q, c_q, e_q, done_q;

   logic           last;
   logic           div_zero;
   logic [W-1:0]   ex_res;
   logic           ex_c;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] mul_nxt;
   logic [W:0]     div_sh, r_nxt;
   logic           div_ge;
   logic [W-1:0]   q_nxt;

   assign last     = (cnt_q == CW'(N_IT - 1));
   assign div_zero = (opd_q == '0);

   // Single-cycle operations
   always_comb begin
      ex_res = '0;
      ex_c   = 1'b0;
      unique case (opc_q)
         OP_LOAD: ex_res = opd_q;
         OP_ADD:  {ex_c, ex_res} = {1'b0, acc_q} + {1'b0, opd_q};
         OP_SUB:  {ex_c, ex_res} = {1'b0, acc_q} - {1'b0, opd_q};
         OP_AND:  ex_res = acc_q & opd_q;
         OP_OR:   ex_res = acc_q | opd_q;
         OP_XOR:  ex_res = acc_q ^ opd_q;
         default: ex_res = acc_q;
      endcase
   end

   // Shift-add: multiplier sits in the low half and is shifted out
   always_comb begin
      mul_sum = {1'b0, prod_q[2*W-1:W]}
              + {1'b0, (prod_q[0] ? opd_q : {W{1'b0}})};
      mul_nxt = {mul_sum, prod_q[W-1:1]};
   end

   // Restoring divide: one quotient bit per step
   always_comb begin
      div_sh = {r_q[W-1:0], quo_q[W-1]};
      div_ge = (div_sh >= {1'b0, opd_q});
      r_nxt  = div_ge ? (div_sh - {1'b0, opd_q}) : div_sh;
      q_nxt  = {quo_q[W-2:0], div_ge};
   end

   always_ff @(posedge C_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (start_i) begin
               if (OPC_i == OP_MUL)      state_d = S_MUL;
               else if (OPC_i == OP_DIV) state_d = S_DIV;
               else                      state_d = S_EXEC;
            end
         S_EXEC: state_d = S_IDLE;
         S_MUL, S_DIV:
            if (last) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q != S_IDLE);
      done_o = done_q;
   end

   assign ACC_o = acc_q;
   assign REM_o = rem_q;
   assign Z_o   = z_q;
   assign C_o   = c_q;
   assign E_o   = e_q;

   always_ff @(posedge C_i) begin
      if (rst_i) begin
         acc_q  <= '0;
         rem_q  <= '0;
         opd_q  <= '0;
         opc_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         prod_q <= '0;
         r_q    <= '0;
         z_q    <= 1'b0;
         c_q    <= 1'b0;
         e_q    <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE:
               if (start_i) begin
                  opc_q  <= OPC_i;
                  opd_q  <= ACT_i;
                  cnt_q  <= '0;
                  prod_q <= {{W{1'b0}}, acc_q};
                  r_q    <= '0;
                  quo_q  <= acc_q;
               end
            S_EXEC: begin
               acc_q  <= ex_res;
               c_q    <= ex_c;
               z_q    <= (ex_res == '0);
               e_q    <= 1'b0;
               done_q <= 1'b1;
            end
            S_MUL: begin
               prod_q <= mul_nxt;
               cnt_q  <= cnt_q + CW'(1);
               if (last) begin
                  acc_q  <= mul_nxt[W-1:0];
                  c_q    <= |mul_nxt[2*W-1:W];
                  z_q    <= (mul_nxt[W-1:0] == '0);
                  e_q    <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            S_DIV: begin
               cnt_q <= cnt_q + CW'(1);
               if (!div_zero) begin
                  r_q   <= r_nxt;
                  quo_q <= q_nxt;
               end
               if (last) begin
                  c_q    <= 1'b0;
                  done_q <= 1'b1;
                  if (div_zero) begin
                     acc_q <= '1;
                     rem_q <= acc_q;
                     z_q   <= 1'b0;
                     e_q   <= 1'b1;
                  end else begin
                     acc_q <= q_nxt;
                     rem_q <= r_nxt[W-1:0];
                     z_q   <= (q_nxt == '0);
                     e_q   <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/alu_acumulador.md
Name: alu_acumulador

Overview:
- Execution unit and main accumulator (ACC) of the 4-bit microprocessor.
- Consumes the operand held in the temporary accumulator and combines it with ACC under a start/busy/done handshake.
- Logic ops, ADD and SUB take one cycle. MUL (shift-add) and DIV (restoring) are iterative and take four cycles.
- Result goes back to ACC. Flags and remainder go to the control unit.

Parameters:
- W, 4, datapath width. Fixed at 4 for this processor; RTL is written generically in W.
- N_IT, 4, iterations for MUL/DIV. Equals W.

Ports:
- C_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; synchronous, active-high
- ACT_i  input  4  operand from the temporary accumulator
- OPC_i  input  3  opcode: 000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 DIV
- start_i  input  1  request; sampled only in IDLE
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle pulse when a result is committed
- ACC_o  output  4  accumulator value
- REM_o  output  4  DIV remainder; holds its value otherwise
- Z_o  output  1  zero flag
- C_o  output  1  carry / borrow / MUL overflow
- E_o  output  1  divide-by-zero error

Behaviour:
- Reset (rst_i=1 at a rising edge): ACC_o, REM_o = 0000; Z_o, C_o, E_o, busy_o, done_o = 0; state = IDLE. Reset has priority over everything and aborts any operation in flight without a done_o pulse.
- States: IDLE, EXEC, MUL, DIV.
- IDLE, start_i=1 at edge N:
  - Capture OPC_i and ACT_i into internal regs; busy_o=1.
  - Go to MUL if opcode 110, DIV if 111, else EXEC.
  - ACT_i and OPC_i are don't-care after edge N.
- EXEC, edge N+1: write result, update flags, done_o=1, busy_o=0, go to IDLE.
  - LOAD: ACC=ACT. Z updated; C, E cleared.
  - ADD: {C,ACC} = ACC+ACT (5-bit sum).
  - SUB: ACC = ACC-ACT mod 16; C=1 when ACC<ACT (borrow).
  - AND/OR/XOR: bitwise; C=0.
  - Z = (new ACC==0) for every opcode. E=0 for every opcode except DIV.
- MUL:
  - Edges N+1..N+4: one shift-add iteration each into an 8-bit product register.
  - Edge N+4 commits: ACC = product[3:0]; C = |product[7:4]; Z from ACC.
  - done_o=1 and busy_o=0 in the cycle after edge N+4, return to IDLE. Total latency 4 cycles.
- DIV (ACC dividend, ACT divisor), restoring algorithm, edges N+1..N+4; commit at N+4:
  - Normal: ACC = quotient, REM_o = remainder, C=0, E=0.
  - ACT==0: no iteration effect. Result ACC=1111, REM_o = original ACC, E=1, C=0. Latency still 4 cycles.
- Handshake:
  - start_i is ignored while busy_o=1.
  - done_o is high only for the cycle in which state is IDLE right after commit. start_i in that same cycle is accepted (back-to-back).
- ACC_o and flags change only at commit edges; intermediate MUL/DIV values are never visible on ACC_o.
- REM_o changes only on DIV commit.

Test Plan:
- Reset, then LOAD ACT=1111 and ADD ACT=0001 → ACC=0000, C=1, Z=1, done_o one cycle after the ADD start edge.
- ACC=0011, SUB ACT=0101 → ACC=1110, C=1, Z=0. Then XOR ACT=1110 → ACC=0000, Z=1, C=0.
- ACC=0011, MUL ACT=0101 → ACC=1111, C=0, done_o 4 cycles after start. ACC=0100, MUL ACT=0100 → ACC=0000, C=1, Z=1.
- ACC=1101, DIV ACT=0011 → ACC=0100, REM=0001, E=0. ACC=0111, DIV ACT=0000 → ACC=1111, REM=0111, E=1.
- Start MUL, pulse start_i=1 with ADD during busy → ignored, MUL result unchanged. Issue start in the done_o cycle → accepted.
- Assert rst_i=1 at the 2nd MUL iteration → next cycle ACC=0000, flags 0, busy_o=0, no done_o pulse.
